// File: rtl/vc_free_signaler.sv
// Tracks per-VC buffer occupancy and busy state of a router input unit and returns
// round-robin "VC free" pulses upstream, one per port per cycle; outputs are registered.
module vc_free_signaler #(
   parameter int NUM_PORTS = 5,
   parameter int NUM_VCS   = 4,
   parameter int BUF_DEPTH = 4,
   parameter int VC_ID_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   parameter int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     buf_write,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     buf_read,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     tail_read,
   output logic [NUM_PORTS*NUM_VCS-1:0]     vc_busy,
   output logic [NUM_PORTS*NUM_VCS*OCC_W-1:0] vc_occupancy,
   output logic [NUM_PORTS-1:0]             vc_free_valid,
   output logic [NUM_PORTS*VC_ID_W-1:0]     vc_free_id,
   output logic                             err_overflow,
   output logic                             err_underflow
);

   localparam int NV = NUM_PORTS * NUM_VCS;

   logic [OCC_W-1:0]   r_occ [NV];
   logic [NV-1:0]      r_busy;
   logic [NV-1:0]      r_pending;
   logic [VC_ID_W-1:0] r_rr [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_free_vld;
   logic [VC_ID_W-1:0] r_free_id [NUM_PORTS];
   logic               r_err_ovf;
   logic               r_err_unf;

   logic [NV-1:0]      w_full;
   logic [NV-1:0]      w_empty;
   logic [NV-1:0]      w_acc_wr;
   logic [NV-1:0]      w_acc_rd;
   logic [NV-1:0]      w_tail_acc;
   logic [NV-1:0]      w_cand;
   logic [NV-1:0]      w_gnt_oh;
   logic [NUM_PORTS-1:0] w_gnt_vld;
   logic [VC_ID_W-1:0] w_gnt_id [NUM_PORTS];
   logic               w_ovf_ev;
   logic               w_unf_ev;

   // First set bit at or after ptr; scanning downward lets the smallest offset win.
   function automatic logic [VC_ID_W-1:0] rr_pick(input logic [NUM_VCS-1:0] c,
                                                  input logic [VC_ID_W-1:0] ptr);
      logic [VC_ID_W-1:0] pick;
      int j;
      pick = '0;
      for (int off = NUM_VCS - 1; off >= 0; off--) begin
         j = int'(ptr) + off;
         if (j >= NUM_VCS) j = j - NUM_VCS;
         if (c[VC_ID_W'(j)]) pick = VC_ID_W'(j);
      end
      return pick;
   endfunction

   always_comb begin
      w_full  = '0;
      w_empty = '0;
      for (int i = 0; i < NV; i++) begin
         w_full[i]  = (r_occ[i] == OCC_W'(BUF_DEPTH));
         w_empty[i] = (r_occ[i] == '0);
      end
   end

   // Simultaneous write+read is always accepted: the slot is recycled in the same cycle.
   assign w_acc_wr   = buf_write & (~w_full  | buf_read);
   assign w_acc_rd   = buf_read  & (~w_empty | buf_write);
   assign w_tail_acc = w_acc_rd & tail_read;
   assign w_cand     = r_pending | w_tail_acc;

   assign w_ovf_ev = |(buf_write & w_full & ~buf_read);
   assign w_unf_ev = (|(buf_read & w_empty & ~buf_write)) |
                     (|(tail_read & ~buf_read)) |
                     (|(w_tail_acc & r_pending));

   always_comb begin
      w_gnt_oh  = '0;
      w_gnt_vld = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_gnt_vld[p] = |w_cand[p*NUM_VCS +: NUM_VCS];
         w_gnt_id[p]  = rr_pick(w_cand[p*NUM_VCS +: NUM_VCS], r_rr[p]);
         for (int v = 0; v < NUM_VCS; v++) begin
            w_gnt_oh[p*NUM_VCS + v] = w_gnt_vld[p] && (w_gnt_id[p] == VC_ID_W'(v));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NV; i++) r_occ[i] <= '0;
         r_busy     <= '0;
         r_pending  <= '0;
         r_free_vld <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_rr[p]      <= '0;
            r_free_id[p] <= '0;
         end
         r_err_ovf  <= 1'b0;
         r_err_unf  <= 1'b0;
      end else begin
         for (int i = 0; i < NV; i++) begin
            if (w_acc_wr[i] && !w_acc_rd[i]) begin
               r_occ[i] <= r_occ[i] + 1'b1;
            end else if (w_acc_rd[i] && !w_acc_wr[i]) begin
               r_occ[i] <= r_occ[i] - 1'b1;
            end
            // A head write alongside the tail read means the next packet already owns the VC.
            r_busy[i] <= w_tail_acc[i] ? w_acc_wr[i] : (r_busy[i] | w_acc_wr[i]);
         end
         r_pending <= w_cand & ~w_gnt_oh;
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_free_vld[p] <= w_gnt_vld[p];
            if (w_gnt_vld[p]) begin
               r_free_id[p] <= w_gnt_id[p];
               r_rr[p]      <= (w_gnt_id[p] == VC_ID_W'(NUM_VCS - 1)) ? '0 : w_gnt_id[p] + 1'b1;
            end
         end
         if (w_ovf_ev) r_err_ovf <= 1'b1;
         if (w_unf_ev) r_err_unf <= 1'b1;
      end
   end

   assign vc_busy       = r_busy;
   assign vc_free_valid = r_free_vld;
   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_unf;

   genvar gi;
   generate
      for (gi = 0; gi < NV; gi++) begin : g_occ
         assign vc_occupancy[gi*OCC_W +: OCC_W] = r_occ[gi];
      end
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_id
         assign vc_free_id[gi*VC_ID_W +: VC_ID_W] = r_free_id[gi];
      end
   endgenerate

endmodule

// File: tb/tb_vc_free_signaler.sv
// Directed bench for vc_free_signaler: occupancy, busy, round-robin free pulses,
// error flags and asynchronous reset, checked with immediate assertions.
module tb_vc_free_signaler;

   logic        clk;
   logic        reset;
   logic [19:0] buf_write;
   logic [19:0] buf_read;
   logic [19:0] tail_read;
   logic [19:0] vc_busy;
   logic [59:0] vc_occupancy;
   logic [4:0]  vc_free_valid;
   logic [9:0]  vc_free_id;
   logic        err_overflow;
   logic        err_underflow;

   int n_chk  = 0;
   int n_pass = 0;

   vc_free_signaler dut (
      .clk           (clk),
      .reset         (reset),
      .buf_write     (buf_write),
      .buf_read      (buf_read),
      .tail_read     (tail_read),
      .vc_busy       (vc_busy),
      .vc_occupancy  (vc_occupancy),
      .vc_free_valid (vc_free_valid),
      .vc_free_id    (vc_free_id),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] b(input int i);
      return 20'd1 << i;
   endfunction

   function automatic logic [31:0] occ(input int i);
      return 32'(vc_occupancy[i*3 +: 3]);
   endfunction

   function automatic logic [31:0] vid(input int p);
      return 32'(vc_free_id[p*2 +: 2]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc(input logic [19:0] w, input logic [19:0] r, input logic [19:0] t);
      buf_write = w;
      buf_read  = r;
      tail_read = t;
      @(posedge clk);
      #1;
      buf_write = '0;
      buf_read  = '0;
      tail_read = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      buf_write = '0;
      buf_read  = '0;
      tail_read = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_busy",  32'(vc_busy), 0);
      chk("rst_occ",   32'(|vc_occupancy), 0);
      chk("rst_valid", 32'(vc_free_valid), 0);
      chk("rst_id",    32'(vc_free_id), 0);
      chk("rst_err",   32'({err_overflow, err_underflow}), 0);

      // Single packet on port0 VC2
      cyc(b(2), 0, 0);
      chk("pkt_occ_w1", occ(2), 1);
      chk("pkt_busy_w1", 32'(vc_busy[2]), 1);
      cyc(b(2), 0, 0);
      chk("pkt_occ_w2", occ(2), 2);
      cyc(b(2), 0, 0);
      chk("pkt_occ_w3", occ(2), 3);
      cyc(0, b(2), 0);
      chk("pkt_occ_r1", occ(2), 2);
      chk("pkt_busy_r1", 32'(vc_busy[2]), 1);
      chk("pkt_novalid_r1", 32'(vc_free_valid), 0);
      cyc(0, b(2), 0);
      chk("pkt_occ_r2", occ(2), 1);
      cyc(0, b(2), b(2));
      chk("pkt_occ_tail", occ(2), 0);
      chk("pkt_busy_tail", 32'(vc_busy[2]), 0);
      chk("pkt_valid", 32'(vc_free_valid), 32'h01);
      chk("pkt_id", vid(0), 2);
      cyc(0, 0, 0);
      chk("pkt_valid_drop", 32'(vc_free_valid), 0);
      chk("pkt_id_hold", vid(0), 2);

      // Simultaneous frees on port4 VCs 0,1,3; VC2 tail joins during the second pulse
      cyc(b(16) | b(17) | b(18) | b(19), 0, 0);
      cyc(0, b(16) | b(17) | b(19), b(16) | b(17) | b(19));
      chk("rr_v1", 32'(vc_free_valid), 32'h10);
      chk("rr_id1", vid(4), 0);
      cyc(0, 0, 0);
      chk("rr_v2", 32'(vc_free_valid), 32'h10);
      chk("rr_id2", vid(4), 1);
      cyc(0, b(18), b(18));
      chk("rr_v3", 32'(vc_free_valid), 32'h10);
      chk("rr_id3", vid(4), 2);
      cyc(0, 0, 0);
      chk("rr_v4", 32'(vc_free_valid), 32'h10);
      chk("rr_id4", vid(4), 3);
      cyc(0, 0, 0);
      chk("rr_v5", 32'(vc_free_valid), 0);
      // Pointer back at 0: VCs 3 and 0 together must grant 0 first
      cyc(b(16) | b(19), 0, 0);
      cyc(0, b(16) | b(19), b(16) | b(19));
      chk("rr_wrap_id1", vid(4), 0);
      cyc(0, 0, 0);
      chk("rr_wrap_id2", vid(4), 3);
      chk("rr_no_err", 32'({err_overflow, err_underflow}), 0);

      // Cross-port independence: port0 VC3 and port3 VC1
      cyc(b(3) | b(13), 0, 0);
      cyc(0, b(3) | b(13), b(3) | b(13));
      chk("xp_valid", 32'(vc_free_valid), 32'h09);
      chk("xp_id0", vid(0), 3);
      chk("xp_id3", vid(3), 1);

      // Tail read and head write on port2 VC1 in the same cycle
      cyc(b(9), 0, 0);
      cyc(b(9), b(9), b(9));
      chk("tw_valid", 32'(vc_free_valid), 32'h04);
      chk("tw_id", vid(2), 1);
      chk("tw_busy", 32'(vc_busy[9]), 1);
      chk("tw_occ", occ(9), 1);

      // Full/empty limits on port1 VC0
      for (int k = 0; k < 4; k++) cyc(b(4), 0, 0);
      chk("lim_occ_full", occ(4), 4);
      chk("lim_ovf_clear", 32'(err_overflow), 0);
      cyc(b(4), 0, 0);
      chk("lim_occ_ovf", occ(4), 4);
      chk("lim_ovf_set", 32'(err_overflow), 1);
      cyc(b(4), b(4), 0);
      chk("lim_occ_wr_rd_full", occ(4), 4);
      chk("lim_unf_after_full", 32'(err_underflow), 0);
      for (int k = 0; k < 4; k++) cyc(0, b(4), 0);
      chk("lim_occ_empty", occ(4), 0);
      cyc(b(4), b(4), 0);
      chk("lim_occ_wr_rd_empty", occ(4), 0);
      chk("lim_unf_wr_rd_empty", 32'(err_underflow), 0);
      cyc(0, b(4), 0);
      chk("lim_occ_unf", occ(4), 0);
      chk("lim_unf_set", 32'(err_underflow), 1);

      // Async reset with port0 VC1 free still pending
      cyc(b(0) | b(1), 0, 0);
      cyc(0, b(0) | b(1), b(0) | b(1));
      chk("pre_rst_valid", 32'(vc_free_valid), 32'h01);
      chk("pre_rst_id", vid(0), 0);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(vc_free_valid), 0);
      chk("mid_rst_id", 32'(vc_free_id), 0);
      chk("mid_rst_busy", 32'(vc_busy), 0);
      chk("mid_rst_occ", 32'(|vc_occupancy), 0);
      chk("mid_rst_err", 32'({err_overflow, err_underflow}), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(0, 0, 0);
      chk("post_rst_valid1", 32'(vc_free_valid), 0);
      cyc(0, 0, 0);
      chk("post_rst_valid2", 32'(vc_free_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
